// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / memory-wait controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W_DEF    = 4;
  localparam int unsigned MEM_WAIT_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-control bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = pipeline_hazard_ctrl_pkg::REG_W_DEF,
  parameter int unsigned CNT_W = pipeline_hazard_ctrl_pkg::CNT_W_DEF
);
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_src1_used;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             mem_req;
  logic [REG_W-1:0] exe_src1;
  logic [REG_W-1:0] exe_src2;
  logic [REG_W-1:0] wb_dest;
  logic             wb_wb_en;
  logic             branch_taken;
  logic             perf_clr;
  logic             freeze_all;
  logic             hold_if_id;
  logic             bubble_id_exe;
  logic             flush;
  logic             sram_en;
  logic             mem_done;
  logic [1:0]       sel_src1;
  logic [1:0]       sel_src2;
  logic [CNT_W-1:0] perf_stall_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, id_src1_used,
           exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_req,
           exe_src1, exe_src2, wb_dest, wb_wb_en,
           branch_taken, perf_clr,
    input  freeze_all, hold_if_id, bubble_id_exe, flush,
           sram_en, mem_done, sel_src1, sel_src2, perf_stall_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, id_src1_used,
           exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_req,
           exe_src1, exe_src2, wb_dest, wb_wb_en,
           branch_taken, perf_clr,
    output freeze_all, hold_if_id, bubble_id_exe, flush,
           sram_en, mem_done, sel_src1, sel_src2, perf_stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Data-SRAM wait-state sequencer: freezes the pipeline for MEM_WAIT+1 cycles per access,
// then gives one DONE cycle in which the pipeline advances.
module mem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  output logic freeze_all,
  output logic sram_en,
  output logic mem_done
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(MEM_WAIT - 1);

  mem_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_all = 1'b0;
    mem_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          freeze_all = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        freeze_all = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_DONE: begin
        mem_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    sram_en = freeze_all | mem_done;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: memory freeze, load/data hazard stall, branch flush, operand forwarding
// and a saturating stall counter. Optional feature macro: FORWARDING_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = MEM_WAIT_DEF,
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  logic             fsm_freeze, fsm_sram_en, fsm_mem_done;
  logic             hazard_c, freeze_c, flush_c, hold_c, stall_c;
  logic [1:0]       sel1_c, sel2_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  mem_wait_fsm #(.MEM_WAIT(MEM_WAIT)) u_mem_wait_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (bus.mem_req),
    .freeze_all (fsm_freeze),
    .sram_en    (fsm_sram_en),
    .mem_done   (fsm_mem_done)
  );

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard_c = bus.exe_mem_r_en & bus.exe_wb_en &
               ((bus.id_src1_used & (bus.id_src1 == bus.exe_dest)) |
                (bus.id_two_src   & (bus.id_src2 == bus.exe_dest)));
    sel1_c = FWD_NONE;
    sel2_c = FWD_NONE;
    if (bus.mem_wb_en && (bus.mem_dest == bus.exe_src1)) sel1_c = FWD_MEM;
    else if (bus.wb_wb_en && (bus.wb_dest == bus.exe_src1)) sel1_c = FWD_WB;
    if (bus.mem_wb_en && (bus.mem_dest == bus.exe_src2)) sel2_c = FWD_MEM;
    else if (bus.wb_wb_en && (bus.wb_dest == bus.exe_src2)) sel2_c = FWD_WB;
  end
`else
  logic unused_fwd_c;

  always_comb begin
    hazard_c = (bus.id_src1_used &
                ((bus.exe_wb_en & (bus.id_src1 == bus.exe_dest)) |
                 (bus.mem_wb_en & (bus.id_src1 == bus.mem_dest)))) |
               (bus.id_two_src &
                ((bus.exe_wb_en & (bus.id_src2 == bus.exe_dest)) |
                 (bus.mem_wb_en & (bus.id_src2 == bus.mem_dest))));
    sel1_c = FWD_NONE;
    sel2_c = FWD_NONE;
  end

  assign unused_fwd_c = ^{bus.exe_src1, bus.exe_src2, bus.wb_dest, bus.wb_wb_en, bus.exe_mem_r_en};
`endif

  // Priority freeze > flush > hazard; everything reads 0 while reset is held.
  always_comb begin
    freeze_c = rst_n & fsm_freeze;
    flush_c  = rst_n & ~freeze_c & bus.branch_taken;
    hold_c   = rst_n & ~freeze_c & ~bus.branch_taken & hazard_c;
    stall_c  = freeze_c | hold_c;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.perf_clr) begin
      cnt_d = '0;
    end else if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.freeze_all     = freeze_c;
  assign bus.hold_if_id     = hold_c;
  assign bus.bubble_id_exe  = hold_c;
  assign bus.flush          = flush_c;
  assign bus.sram_en        = rst_n & fsm_sram_en;
  assign bus.mem_done       = rst_n & fsm_mem_done;
  assign bus.sel_src1       = {2{rst_n}} & sel1_c;
  assign bus.sel_src2       = {2{rst_n}} & sel2_c;
  assign bus.perf_stall_cnt = cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing block for the 5-stage ARM-subset pipeline (IF/ID/EXE/MEM/WB). It consumes decoded control bits (WB_EN, MEM_R_EN, MEM_W_EN, B) as they travel down the stages. It produces freeze, bubble and flush controls, plus a wait-state FSM that holds the whole pipeline while the multi-cycle data SRAM completes an access. An optional forwarding-select path is included, together with a saturating stall counter for performance analysis.

Parameters:
MEM_WAIT, 4, SRAM wait cycles per access; legal range 1..15
REG_W, 4, register-index width
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_src1  in  REG_W  ID-stage Rn
id_src2  in  REG_W  ID-stage Rm (or Rd for STR)
id_two_src  in  1  id_src2 is read
id_src1_used  in  1  id_src1 is read (0 for MOV/MVN/B)
exe_dest  in  REG_W  EXE-stage destination
exe_wb_en  in  1  EXE-stage WB_EN
exe_mem_r_en  in  1  EXE-stage MEM_R_EN (LDR)
mem_dest  in  REG_W  MEM-stage destination
mem_wb_en  in  1  MEM-stage WB_EN
mem_req  in  1  MEM-stage MEM_R_EN|MEM_W_EN
exe_src1  in  REG_W  EXE-stage Rn (forwarding only)
exe_src2  in  REG_W  EXE-stage Rm (forwarding only)
wb_dest  in  REG_W  WB-stage destination (forwarding only)
wb_wb_en  in  1  WB-stage WB_EN (forwarding only)
branch_taken  in  1  EXE-stage branch resolved taken
perf_clr  in  1  synchronous clear of stall counter
freeze_all  out  1  hold every pipeline register and PC
hold_if_id  out  1  hold PC and IF/ID register
bubble_id_exe  out  1  zero control bits entering EXE
flush  out  1  clear IF/ID and ID/EXE (branch)
sram_en  out  1  SRAM access in progress
mem_done  out  1  one-cycle pulse: access complete
sel_src1  out  2  EXE operand-1 forward select
sel_src2  out  2  EXE operand-2 forward select
perf_stall_cnt  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset (rst_n=0, asynchronous): FSM to IDLE, wait counter to 0, perf_stall_cnt to 0. All outputs read 0 while reset is held.
- Memory FSM states are IDLE, WAIT and DONE.
  - IDLE & mem_req: load cnt=MEM_WAIT-1, go to WAIT.
  - WAIT: cnt-- each cycle; at cnt==0 go to DONE.
  - DONE: go to IDLE unconditionally.
- freeze_all = (IDLE & mem_req) | WAIT. This gives MEM_WAIT+1 frozen cycles per access.
- sram_en = freeze_all | DONE.
- mem_done = DONE. In the DONE cycle the pipeline advances. mem_req seen in IDLE on the next cycle is treated as a new instruction, so back-to-back accesses are supported.
- Data hazard (combinational, ID stage), without forwarding: hazard when
  - (id_src1_used & id_src1 matches exe_dest/exe_wb_en or mem_dest/mem_wb_en), or
  - (id_two_src & id_src2 matches the same).
- On a hazard, hold_if_id=1 and bubble_id_exe=1 in the same cycle.
- Priority is freeze_all > flush > hazard.
  - While freeze_all=1, hold_if_id, bubble_id_exe and flush are 0.
  - branch_taken is honoured in the first cycle freeze_all drops. EXE is frozen, so branch_taken is held by the pipeline.
  - flush=1 suppresses hold_if_id and bubble_id_exe.
- perf_stall_cnt increments every cycle in which freeze_all|hold_if_id is 1, and saturates at all-ones.
- perf_clr takes priority over increment.

Optional Feature:
FORWARDING_EN
- Defined:
  - Hazard is reduced to load-use only: exe_mem_r_en & exe_wb_en & an ID source matching exe_dest.
  - sel_srcN = 2'b01 when mem_wb_en & mem_dest==exe_srcN.
  - Otherwise sel_srcN = 2'b10 when wb_wb_en & wb_dest==exe_srcN.
  - Otherwise sel_srcN = 2'b00. The MEM stage wins over WB.
- Undefined: sel_src1 and sel_src2 are tied to 2'b00; exe_src*, wb_dest and wb_wb_en are ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2.
  - Forward-select constants: FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_W default.
- One sub-module, mem_wait_fsm, contains the FSM and counter and outputs freeze_all, sram_en and mem_done.
- Hazard, forwarding and perf logic stay in the top.

Test Plan:
- MEM_WAIT=4, mem_req=1 from cycle 0 → freeze_all=1 in cycles 0-4; mem_done=1 and freeze_all=0 in cycle 5; sram_en=1 in cycles 0-5.
- rst_n pulsed low in cycle 2 of the above → immediate freeze_all=0 and sram_en=0. After release with mem_req=0, FSM stays IDLE and mem_done is never asserted.
- No forwarding: id_src1=3, id_src1_used=1, exe_dest=3, exe_wb_en=1 → hold_if_id=1 and bubble_id_exe=1 in the same cycle. Repeat with exe_wb_en=0 → both 0.
- branch_taken=1 during WAIT → flush=0 until the DONE cycle, then flush=1 with hold_if_id=0.
- FORWARDING_EN: exe_src1=5, mem_dest=5, mem_wb_en=1, wb_dest=5, wb_wb_en=1 → sel_src1=01. exe_mem_r_en=1, exe_dest=id_src2=7, id_two_src=1 → hold_if_id=1.
- CNT_W=4, hold_if_id held for 20 cycles → perf_stall_cnt=15 and stays there. perf_clr=1 → 0 next cycle.
